pes_fdiv: RTL and testbench

- Sequential signed fixed-point divider. It is the inverse of the team's 8x8 signed fractional multiplier.
- Takes a 16-bit signed product-domain dividend and an 8-bit signed divisor. Returns an 8-bit signed quotient and remainder.
- Uses iterative restoring division on magnitudes: one quotient bit per clock.
- Sits downstream of the multiplier pipeline to recover a factor, or to normalise fractions. Uses a valid/ready handshake on both sides.

---
 rtl/pes_fixed_pkg.sv | 25 ++
 rtl/pes_fdiv_step.sv | 26 ++
 rtl/pes_fdiv.sv | 163 ++++++++++++++++
 tb/tb_pes_fdiv.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pes_fixed_pkg.sv
// Shared definitions for the signed fixed-point arithmetic blocks.
package pes_fixed_pkg;

  // Default operand width; products are 2*W_DEF bits wide.
  localparam int W_DEF = 8;

  // Saturation limits for a W_DEF-bit signed result.
  localparam logic signed [W_DEF-1:0] QMAX = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic signed [W_DEF-1:0] QMIN = {1'b1, {(W_DEF-1){1'b0}}};

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } fdiv_state_e;

  // Magnitude of a signed value. The most negative input maps to its true
  // positive magnitude because the result is read as unsigned.
  function automatic logic [31:0] abs_u(input logic signed [31:0] v);
    return v[31] ? unsigned'(-v) : unsigned'(v);
  endfunction

endpackage

// File: rtl/pes_fdiv_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor magnitude, keep or restore, and emit the quotient bit.
module pes_fdiv_step
  import pes_fixed_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0] i_rem,
  input  logic       i_bit,
  input  logic [W:0] i_dsr,
  output logic [W:0] o_rem,
  output logic       o_q
);

  logic [W+1:0] w_shifted;
  logic [W+1:0] w_diff;

  // Trial subtraction one bit wider than the remainder so the borrow is visible.
  always_comb begin
    w_shifted = {i_rem, i_bit};
    w_diff    = w_shifted - {1'b0, i_dsr};
    o_q       = ~w_diff[W+1];
    o_rem     = o_q ? w_diff[W:0] : w_shifted[W:0];
  end

endmodule

// File: rtl/pes_fdiv.sv
// Sequential signed fixed-point divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per clock, saturating quotient, sign-of-dividend remainder.
module pes_fdiv
  import pes_fixed_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [2*W-1:0] dividend,
  input  logic signed [W-1:0]   divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W-1:0]   quotient,
  output logic signed [W-1:0]   remainder,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int LAT = 2*W + 1;
  localparam int CW  = $clog2(2*W);
  localparam logic [CW-1:0] L_CNT_LOAD = CW'(LAT - 2);

  localparam logic [2*W-1:0]   L_POS_LIM = (2*W)'((1 << (W-1)) - 1);
  localparam logic [2*W-1:0]   L_NEG_LIM = (2*W)'(1 << (W-1));
  localparam logic signed [W-1:0] L_QMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] L_QMIN = {1'b1, {(W-1){1'b0}}};

  fdiv_state_e r_state;
  fdiv_state_e w_next_state;

  // Working register: dividend bits shift out the top, quotient bits in the bottom.
  logic [2*W-1:0] r_work;
  logic [W:0]     r_rem;
  logic [W:0]     r_dsr;
  logic           r_sign_q;
  logic           r_sign_r;
  logic           r_zero;
  logic [CW-1:0]  r_cnt;

  logic                r_out_valid;
  logic signed [W-1:0] r_quotient;
  logic signed [W-1:0] r_remainder;
  logic                r_overflow;
  logic                r_div_by_zero;

  logic [2*W-1:0]      w_dvd_abs;
  logic [W:0]          w_dsr_abs;
  logic [W:0]          w_step_rem;
  logic                w_step_q;
  logic                w_q_sat;
  logic [W-1:0]        w_rem_mag;
  logic signed [W-1:0] w_fix_quot;
  logic signed [W-1:0] w_fix_rem;
  logic                w_fix_ovf;

  assign w_dvd_abs = (2*W)'(abs_u(32'(dividend)));
  assign w_dsr_abs = (W+1)'(abs_u(32'(divisor)));

  pes_fdiv_step #(.W(W)) u_step (
    .i_rem (r_rem),
    .i_bit (r_work[2*W-1]),
    .i_dsr (r_dsr),
    .o_rem (w_step_rem),
    .o_q   (w_step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples pre-edge values regardless of block ordering.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default comes first so no path through the case leaves the
    // signal unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)      w_next_state = CALC;
      CALC:    if (r_cnt == '0)   w_next_state = FIX;
      FIX:                        w_next_state = DONE;
      DONE:    if (out_ready)     w_next_state = IDLE;
      default:                    w_next_state = IDLE;
    endcase
  end

  // Signed result, saturation and divide-by-zero override, evaluated for FIX.
  always_comb begin
    w_rem_mag  = r_rem[W-1:0];
    w_q_sat    = r_sign_q ? (r_work > L_NEG_LIM) : (r_work > L_POS_LIM);
    w_fix_quot = r_sign_q ? -r_work[W-1:0] : r_work[W-1:0];
    w_fix_rem  = r_sign_r ? -w_rem_mag : w_rem_mag;
    w_fix_ovf  = 1'b0;
    if (r_zero) begin
      w_fix_quot = r_sign_r ? L_QMIN : L_QMAX;
      w_fix_rem  = '0;
    end else if (w_q_sat) begin
      w_fix_quot = r_sign_q ? L_QMIN : L_QMAX;
      w_fix_ovf  = 1'b1;
    end
  end

  // Datapath: operand capture, iteration, result registers and out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work        <= '0;
      r_rem         <= '0;
      r_dsr         <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_zero        <= 1'b0;
      r_cnt         <= '0;
      r_out_valid   <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work   <= w_dvd_abs;
            r_dsr    <= w_dsr_abs;
            r_sign_q <= dividend[2*W-1] ^ divisor[W-1];
            r_sign_r <= dividend[2*W-1];
            r_zero   <= (divisor == '0);
            r_rem    <= '0;
            r_cnt    <= L_CNT_LOAD;
          end
        end
        CALC: begin
          r_rem  <= w_step_rem;
          r_work <= {r_work[2*W-2:0], w_step_q};
          r_cnt  <= r_cnt - CW'(1);
        end
        FIX: begin
          r_quotient    <= w_fix_quot;
          r_remainder   <= w_fix_rem;
          r_overflow    <= w_fix_ovf;
          r_div_by_zero <= r_zero;
          r_out_valid   <= 1'b1;
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign overflow    = r_overflow;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_pes_fdiv.sv
// Self-checking bench for pes_fdiv: directed corner cases, backpressure,
// mid-operation reset and randomized operands against an arithmetic model.
module tb_pes_fdiv;

  localparam int W   = 8;
  localparam int LAT = 2*W + 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [2*W-1:0] dividend;
  logic signed [W-1:0]   divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [W-1:0]   quotient;
  logic signed [W-1:0]   remainder;
  logic                  overflow;
  logic                  div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  pes_fdiv #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: integer division truncates toward zero and % takes the
  // dividend's sign; saturate to the 8-bit signed range.
  function automatic void model(input int a, input int b, output int q,
                                output int r, output int ovf, output int dbz);
    if (b == 0) begin
      q = (a >= 0) ? 127 : -128;
      r = 0; ovf = 0; dbz = 1;
    end else begin
      q = a / b; r = a % b; ovf = 0; dbz = 0;
      if (q > 127)       begin q = 127;  ovf = 1; end
      else if (q < -128) begin q = -128; ovf = 1; end
    end
  endfunction

  // Present operands, wait (bounded) for the result, compare it and handshake.
  task automatic run_op(input int a, input int b, input string tag);
    int q, r, ovf, dbz, cyc;
    model(a, b, q, r, ovf, dbz);
    @(negedge clk);
    dividend  = 16'(a);
    divisor   = 8'(b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"},  cyc, LAT);
    check({tag, "_quot"}, quotient, q);
    check({tag, "_rem"},  remainder, r);
    check({tag, "_ovf"},  {31'd0, overflow}, ovf);
    check({tag, "_dbz"},  {31'd0, div_by_zero}, dbz);
    @(posedge clk); #1;
    check({tag, "_vdrop"}, {31'd0, out_valid}, 0);
    check({tag, "_rdy"},   {31'd0, in_ready}, 1);
  endtask

  initial begin
    int q, r, ovf, dbz, cyc, seen;
    logic signed [7:0]  rx, ry;
    logic signed [15:0] rd;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_ready", {31'd0, in_ready}, 1);
    check("rst_quot",  quotient, 0);
    check("rst_rem",   remainder, 0);
    check("rst_ovf",   {31'd0, overflow}, 0);
    check("rst_dbz",   {31'd0, div_by_zero}, 0);
    @(negedge clk); reset = 1'b0;

    // Directed arithmetic cases.
    run_op(-273,   -13,  "prod_inv");
    run_op(100,    7,    "p100_7");
    run_op(-100,   7,    "m100_7");
    run_op(100,    -7,   "p100_m7");
    run_op(-32768, -128, "extreme");
    run_op(16384,  1,    "ovf_pos");
    run_op(-16384, 1,    "ovf_neg");
    run_op(-128,   1,    "min_exact");
    run_op(500,    0,    "dbz_pos");
    run_op(-5,     0,    "dbz_neg");
    run_op(0,      0,    "dbz_zero");

    // Backpressure: result held for 10 cycles while new operands are ignored.
    model(1000, -9, q, r, ovf, dbz);
    @(negedge clk);
    dividend = 16'sd1000; divisor = -8'sd9; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_lat", cyc, LAT);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; dividend = 16'sd77; divisor = 8'sd3;
      @(posedge clk); #1;
      check("bp_valid", {31'd0, out_valid}, 1);
      check("bp_ready", {31'd0, in_ready}, 0);
      check("bp_quot",  quotient, q);
      check("bp_rem",   remainder, r);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_vdrop", {31'd0, out_valid}, 0);
    check("bp_rdy",   {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    check("bp_idle",  {31'd0, in_ready}, 1);
    check("bp_hold",  quotient, q);

    // Reset during CALC discards the operation and clears outputs.
    @(negedge clk);
    dividend = 16'sd100; divisor = 8'sd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_valid", {31'd0, out_valid}, 0);
    check("mrst_ready", {31'd0, in_ready}, 1);
    check("mrst_quot",  quotient, 0);
    check("mrst_rem",   remainder, 0);
    check("mrst_ovf",   {31'd0, overflow}, 0);
    check("mrst_dbz",   {31'd0, div_by_zero}, 0);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("mrst_noout", seen, 0);
    run_op(100, 7, "post_rst");

    // Randomized: exact products and arbitrary operand pairs.
    for (int i = 0; i < 15; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      if (ry == 0) ry = 8'sd1;
      run_op(int'(rx) * int'(ry), int'(ry), "rnd_prod");
    end
    for (int i = 0; i < 15; i++) begin
      rd = 16'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 8'sd0 : 8'($urandom);
      run_op(int'(rd), int'(ry), "rnd_any");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
